// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI write initiator: frame geometry, register
// bank addresses, the controller state enum and a frame-building helper.
// -----------------------------------------------------------------------------
package spi_pkg;

    localparam int FRAME_W = 16;
    localparam int ADDR_W  = 7;
    localparam int DATA_W  = 8;

    // Only writes are ever issued, so bit 15 of every frame is constant.
    localparam logic WRITE_BIT = 1'b1;

    // Register bank on the far side of the link
    localparam logic [ADDR_W-1:0] ADDR_EN_OUT_7_0  = 7'h00;
    localparam logic [ADDR_W-1:0] ADDR_EN_OUT_15_8 = 7'h01;
    localparam logic [ADDR_W-1:0] ADDR_EN_PWM_7_0  = 7'h02;
    localparam logic [ADDR_W-1:0] ADDR_EN_PWM_15_8 = 7'h03;
    localparam logic [ADDR_W-1:0] ADDR_PWM_DUTY    = 7'h04;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_HIGH,
        ST_LOW,
        ST_HOLD,
        ST_GAP
    } spi_state_e;

    // Assemble one write frame: {write flag, address, data}, sent MSB first.
    function automatic logic [FRAME_W-1:0] build_frame(
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] data
    );
        return {WRITE_BIT, addr, data};
    endfunction

    // Largest of the four timing parameters; sizes the phase counter.
    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/spi_controller_if.sv
// -----------------------------------------------------------------------------
// spi_controller_if
// Request handshake and status bundle between a requester and spi_controller.
//   req_valid  requester -> controller  write request present
//   req_ready  controller -> requester  request can be accepted this cycle
//   req_addr   requester -> controller  target register address (7 bits)
//   req_data   requester -> controller  register write data (8 bits)
//   busy       controller -> requester  frame in progress
//   done       controller -> requester  one-cycle pulse at frame completion
// -----------------------------------------------------------------------------
interface spi_controller_if;
    import spi_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_data;
    logic              busy;
    logic              done;

    modport master (
        output req_valid,
        output req_addr,
        output req_data,
        input  req_ready,
        input  busy,
        input  done
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        input  req_data,
        output req_ready,
        output busy,
        output done
    );

endinterface

// File: rtl/spi_phase_timer.sv
// -----------------------------------------------------------------------------
// spi_phase_timer
// Loadable down-counter that times every phase of the SPI frame.
// Loading N-1 makes the phase last exactly N cycles: expired_o is high in the
// last cycle of the phase, and the counter parks at zero until reloaded.
//   clk         system clock
//   rst         synchronous active-high reset (counter -> 0)
//   load_i      load load_val_i on the next edge
//   load_val_i  phase length minus one
//   expired_o   counter is zero (current phase ends at the next edge)
// -----------------------------------------------------------------------------
module spi_phase_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             expired_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == '0);

endmodule

// File: rtl/spi_controller.sv
// -----------------------------------------------------------------------------
// spi_controller
// SPI mode-0 write initiator. A request accepted over the valid/ready
// handshake is sent as one 16-bit frame {1, addr[6:0], data[7:0]} MSB first.
// COPI changes only while SCLK is low; SCLK idles low, nCS idles high.
//   clk   system clock
//   rst   synchronous active-high reset; aborts any frame in flight
//   bus   request handshake / busy / done (spi_controller_if.slave)
//   SCLK  serial clock
//   COPI  serial data out
//   nCS   active-low chip select
// Parameters (all in clk cycles):
//   CLK_DIV   SCLK half-period (>= 2)
//   CS_SETUP  nCS low before the first SCLK rise (>= 2)
//   CS_HOLD   SCLK low after the last fall before nCS rises (>= 2)
//   CS_IDLE   minimum nCS high time between frames (>= 3)
// -----------------------------------------------------------------------------
module spi_controller
    import spi_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 4,
    parameter int CS_HOLD  = 4,
    parameter int CS_IDLE  = 4
) (
    input  logic             clk,
    input  logic             rst,
    spi_controller_if.slave  bus,
    output logic             SCLK,
    output logic             COPI,
    output logic             nCS
);

    // The minimums let a 2-FF synchroniser plus edge detector on the
    // receiving side observe every SCLK level and every nCS transition.
    generate
        if (CLK_DIV < 2) begin : g_bad_clk_div
            $error("spi_controller: CLK_DIV must be >= 2");
        end
        if (CS_SETUP < 2) begin : g_bad_cs_setup
            $error("spi_controller: CS_SETUP must be >= 2");
        end
        if (CS_HOLD < 2) begin : g_bad_cs_hold
            $error("spi_controller: CS_HOLD must be >= 2");
        end
        if (CS_IDLE < 3) begin : g_bad_cs_idle
            $error("spi_controller: CS_IDLE must be >= 3");
        end
    endgenerate

    localparam int MAX_LOAD = max4(CLK_DIV, CS_SETUP, CS_HOLD, CS_IDLE);
    localparam int CNT_W    = $clog2(MAX_LOAD);

    localparam logic [CNT_W-1:0] LOAD_DIV   = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] LOAD_SETUP = CNT_W'(CS_SETUP - 1);
    localparam logic [CNT_W-1:0] LOAD_HOLD  = CNT_W'(CS_HOLD - 1);
    localparam logic [CNT_W-1:0] LOAD_IDLE  = CNT_W'(CS_IDLE - 1);
    localparam logic [3:0]       LAST_BIT   = 4'(FRAME_W - 1);

    spi_state_e         state_q, state_d;
    logic               sclk_q, sclk_d;
    logic               copi_q, copi_d;
    logic               ncs_q, ncs_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [FRAME_W-1:0] shift_q, shift_d;
    logic [3:0]         bit_cnt_q, bit_cnt_d;

    logic               tmr_load;
    logic [CNT_W-1:0]   tmr_val;
    logic               tmr_expired;

    logic               accept;

    spi_phase_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .expired_o  (tmr_expired)
    );

    // Ready is combinational so a request is taken the first cycle the
    // controller is back in IDLE; it is held low while reset is asserted.
    assign bus.req_ready = (state_q == ST_IDLE) && !rst;
    assign accept        = bus.req_valid && bus.req_ready;

    always_comb begin
        state_d   = state_q;
        sclk_d    = sclk_q;
        copi_d    = copi_q;
        ncs_d     = ncs_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        tmr_load  = 1'b0;
        tmr_val   = '0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    shift_d   = build_frame(bus.req_addr, bus.req_data);
                    copi_d    = WRITE_BIT;
                    ncs_d     = 1'b0;
                    busy_d    = 1'b1;
                    bit_cnt_d = '0;
                    tmr_load  = 1'b1;
                    tmr_val   = LOAD_SETUP;
                    state_d   = ST_SETUP;
                end
            end

            ST_SETUP: begin
                if (tmr_expired) begin
                    sclk_d   = 1'b1;
                    tmr_load = 1'b1;
                    tmr_val  = LOAD_DIV;
                    state_d  = ST_HIGH;
                end
            end

            ST_HIGH: begin
                if (tmr_expired) begin
                    sclk_d   = 1'b0;
                    tmr_load = 1'b1;
                    if (bit_cnt_q == LAST_BIT) begin
                        copi_d  = 1'b0;
                        tmr_val = LOAD_HOLD;
                        state_d = ST_HOLD;
                    end else begin
                        // Rotate rather than shift so the register stays
                        // fully used; the wrapped bits are never sent.
                        shift_d   = {shift_q[FRAME_W-2:0], shift_q[FRAME_W-1]};
                        copi_d    = shift_q[FRAME_W-2];
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        tmr_val   = LOAD_DIV;
                        state_d   = ST_LOW;
                    end
                end
            end

            ST_LOW: begin
                if (tmr_expired) begin
                    sclk_d   = 1'b1;
                    tmr_load = 1'b1;
                    tmr_val  = LOAD_DIV;
                    state_d  = ST_HIGH;
                end
            end

            ST_HOLD: begin
                if (tmr_expired) begin
                    ncs_d    = 1'b1;
                    done_d   = 1'b1;
                    tmr_load = 1'b1;
                    tmr_val  = LOAD_IDLE;
                    state_d  = ST_GAP;
                end
            end

            ST_GAP: begin
                if (tmr_expired) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            sclk_q    <= 1'b0;
            copi_q    <= 1'b0;
            ncs_q     <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            shift_q   <= '0;
            bit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            sclk_q    <= sclk_d;
            copi_q    <= copi_d;
            ncs_q     <= ncs_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    assign SCLK     = sclk_q;
    assign COPI     = copi_q;
    assign nCS      = ncs_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_spi_controller.sv
// -----------------------------------------------------------------------------
// tb_spi_controller
// Two controllers share one stimulus stream: instance 0 with default timing,
// instance 1 with the minimum legal timing. Each instance has a timing model
// derived from the frame rules (position k cycles after acceptance) that is
// compared against all pins every cycle, plus a pin-level monitor that
// rebuilds frames from SCLK rises and measures nCS / SCLK timing.
// -----------------------------------------------------------------------------
module tb_spi_controller;
    import spi_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic [6:0] req_addr;
    logic [7:0] req_data;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_dut
            localparam int D = (gi == 0) ? 4 : 2;
            localparam int S = (gi == 0) ? 4 : 2;
            localparam int H = (gi == 0) ? 4 : 2;
            localparam int I = (gi == 0) ? 4 : 3;
            localparam int L = S + 31 * D + H;
            localparam int L_LIT = (gi == 0) ? 132 : 66;

            spi_controller_if bus ();
            logic sclk, copi, ncs;

            assign bus.req_valid = req_valid;
            assign bus.req_addr  = req_addr;
            assign bus.req_data  = req_data;

            spi_controller #(
                .CLK_DIV  (D),
                .CS_SETUP (S),
                .CS_HOLD  (H),
                .CS_IDLE  (I)
            ) u_dut (
                .clk  (clk),
                .rst  (rst),
                .bus  (bus.slave),
                .SCLK (sclk),
                .COPI (copi),
                .nCS  (ncs)
            );

            // model state: cycles since acceptance, frame being sent
            bit          m_active = 1'b0;
            int          m_k      = 0;
            logic [15:0] m_frame  = '0;

            // monitor state
            logic [15:0] frames[$];
            int          gaps[$];
            int          nrise     = 0;
            logic [15:0] bits      = '0;
            int          low_len   = 0;
            int          high_len  = 0;
            int          done_cnt  = 0;
            int          sclk_run  = 0;
            bit          abort     = 1'b0;
            bit          have_prev = 1'b0;
            logic        prev_sclk = 1'b0;
            logic        prev_ncs  = 1'b1;

            always @(posedge clk) begin
                bit   rst_at_edge;
                bit   m_ready;
                bit   e_busy, e_ncs, e_done, e_sclk, e_copi, e_ready;
                int   idx;

                // model update from the inputs seen at this edge
                rst_at_edge = rst;
                m_ready = !rst && !(m_active && m_k < L + I);
                if (rst) begin
                    m_active = 1'b0;
                end else if (m_ready && req_valid) begin
                    m_active = 1'b1;
                    m_k      = 0;
                    m_frame  = {WRITE_BIT, req_addr, req_data};
                end else if (m_active && m_k < L + I) begin
                    m_k++;
                end

                #1;
                if (chk_en) begin
                    e_busy = m_active && (m_k < L + I);
                    e_ncs  = !(m_active && (m_k < L));
                    e_done = m_active && (m_k == L);
                    e_sclk = m_active && (m_k >= S) && (m_k < S + 31 * D)
                             && ((((m_k - S) / D) % 2) == 0);
                    e_copi = 1'b0;
                    if (m_active && m_k < S + 31 * D) begin
                        idx    = (m_k < S) ? 0 : (m_k - S + D) / (2 * D);
                        e_copi = m_frame[15 - idx];
                    end
                    e_ready = !rst && !e_busy;
                    check($sformatf("pins%0d{rdy,busy,done,sclk,copi,ncs}", gi),
                          int'({bus.req_ready, bus.busy, bus.done, sclk, copi, ncs}),
                          int'({e_ready, e_busy, e_done, e_sclk, e_copi, e_ncs}));

                    // pin-level monitor
                    if (rst_at_edge) abort = 1'b1;
                    if (!ncs && prev_ncs) begin
                        if (have_prev && !abort) begin
                            check($sformatf("gap%0d", gi), int'(high_len >= I + 1), 1);
                            gaps.push_back(high_len);
                        end
                        abort    = 1'b0;
                        low_len  = 0;
                        nrise    = 0;
                        done_cnt = 0;
                        bits     = '0;
                    end
                    if (bus.done) done_cnt++;
                    if (sclk != prev_sclk) begin
                        if (!sclk && !abort)
                            check($sformatf("sclk_high%0d", gi), sclk_run, D);
                        if (sclk) begin
                            if (nrise > 0 && !abort)
                                check($sformatf("sclk_low%0d", gi), sclk_run, D);
                            nrise++;
                            bits = {bits[14:0], copi};
                        end
                        sclk_run = 1;
                    end else begin
                        sclk_run++;
                    end
                    if (ncs && !prev_ncs) begin
                        if (!abort) begin
                            check($sformatf("ncs_low%0d", gi), low_len, L_LIT);
                            check($sformatf("rises%0d", gi), nrise, 16);
                            check($sformatf("done_once%0d", gi), done_cnt, 1);
                            frames.push_back(bits);
                            have_prev = 1'b1;
                            $display("dut%0d frame 0x%04h nCS low %0d cycles", gi, bits, low_len);
                        end else begin
                            have_prev = 1'b0;
                            $display("dut%0d frame aborted by reset after %0d rises", gi, nrise);
                        end
                        high_len = 0;
                    end
                    if (!ncs) low_len++;
                    else      high_len++;
                    prev_sclk = sclk;
                    prev_ncs  = ncs;
                end
            end
        end
    endgenerate

    // Present a request and wait until instance 0 takes it.
    task automatic send(input logic [6:0] a, input logic [7:0] d, input bit hold);
        int n;
        req_valid = 1'b1;
        req_addr  = a;
        req_data  = d;
        n = 0;
        while (g_dut[0].bus.req_ready !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("accept_timeout", int'(n < 400), 1);
        @(negedge clk);
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic wait_frames(input int n);
        int c;
        c = 0;
        while (g_dut[0].frames.size() < n && c < 2000) begin
            @(negedge clk);
            c++;
        end
        check("frame_timeout", int'(c < 2000), 1);
    endtask

    function automatic int last_frame0();
        int n;
        n = g_dut[0].frames.size();
        return (n > 0) ? int'(g_dut[0].frames[n-1]) : -1;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int nf;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        req_data  = '0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // idle after reset
        repeat (20) @(negedge clk);
        check("idle_ready", int'(g_dut[0].bus.req_ready), 1);
        check("idle_ncs", int'(g_dut[0].ncs), 1);
        check("idle_busy", int'(g_dut[0].bus.busy), 0);

        // single write
        send(ADDR_PWM_DUTY, 8'hA5, 1'b0);
        wait_frames(1);
        check("frame_84A5", last_frame0(), 32'h84A5);

        // back-to-back with valid held
        send(ADDR_EN_OUT_7_0, 8'hFF, 1'b1);
        send(ADDR_EN_OUT_15_8, 8'h0F, 1'b0);
        wait_frames(3);
        check("frame_80FF", int'(g_dut[0].frames[1]), 32'h80FF);
        check("frame_810F", last_frame0(), 32'h810F);
        check("b2b_gap", (g_dut[0].gaps.size() > 0) ?
              g_dut[0].gaps[g_dut[0].gaps.size()-1] : -1, 5);

        // data changed mid-frame only affects the next frame
        send(ADDR_EN_PWM_7_0, 8'h11, 1'b1);
        repeat (30) @(negedge clk);
        req_data = 8'h22;
        send(ADDR_EN_PWM_7_0, 8'h22, 1'b0);
        wait_frames(5);
        check("frame_8211", int'(g_dut[0].frames[3]), 32'h8211);
        check("frame_8222", last_frame0(), 32'h8222);

        // reset mid-frame at the 7th SCLK rise
        wait_frames(5);
        send(ADDR_EN_PWM_15_8, 8'h3C, 1'b0);
        nf = 0;
        while (g_dut[0].nrise < 7 && nf < 400) begin
            @(negedge clk);
            nf++;
        end
        check("rise7_timeout", int'(nf < 400), 1);
        nf = g_dut[0].frames.size();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_ncs", int'(g_dut[0].ncs), 1);
        check("abort_sclk", int'(g_dut[0].sclk), 0);
        check("abort_copi", int'(g_dut[0].copi), 0);
        repeat (200) @(negedge clk);
        check("abort_no_frame", g_dut[0].frames.size(), nf);

        send(ADDR_EN_OUT_15_8, 8'h5A, 1'b0);
        wait_frames(nf + 1);
        check("frame_815A", last_frame0(), 32'h815A);

        repeat (200) @(negedge clk);
        check("dut1_frames_seen", int'(g_dut[1].frames.size() >= 6), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
